// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared constants for the four-channel round-robin one-hot arbiter:
// channel count, FSM state encodings, timeout counter width and the
// channel to priority-encoder input mapping (req[3..0] -> a,b,c,d).
package rr_onehot_arbiter_pkg;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  // 1-bit state register encodings
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  // Channel index feeding each encoder input
  localparam logic [1:0] ENC_A_IDX = 2'd3;
  localparam logic [1:0] ENC_B_IDX = 2'd2;
  localparam logic [1:0] ENC_C_IDX = 2'd1;
  localparam logic [1:0] ENC_D_IDX = 2'd0;

  // Index of the hot bit of a one-hot channel vector (0 when empty)
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
    logic [1:0] idx;
    idx = ENC_D_IDX;
    if (oh[ENC_A_IDX])      idx = ENC_A_IDX;
    else if (oh[ENC_B_IDX]) idx = ENC_B_IDX;
    else if (oh[ENC_C_IDX]) idx = ENC_C_IDX;
    return idx;
  endfunction

endpackage

// File: rtl/rr_onehot_arbiter_pick4.sv
// rr_pick4: combinational round-robin search. Starting at ptr and
// walking downward (ptr, ptr-1, ... wrapping 0 -> 3), the first pending
// channel wins and is returned one-hot. No pending bits -> win = 0.
module rr_pick4
  import rr_onehot_arbiter_pkg::*;
(
  input  logic [NUM_CH-1:0] pending,
  input  logic [1:0]        ptr,
  output logic [NUM_CH-1:0] win
);

  logic       found;
  logic [1:0] idx;

  // Scan from ptr downward, keep only the first pending channel
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = ptr - 2'(k);
      if (!found && pending[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: captures single-cycle request pulses into pending
// bits, picks one winner with round-robin priority and offers it as a
// registered one-hot grant.
//
// Handshake: an offer is present while gnt_valid=1; gnt and gnt_valid stay
// stable until the edge where gnt_valid & gnt_ready are both high (the
// transfer), or until the offer is withdrawn after READY_TIMEOUT cycles
// without ready (tmo pulses). Ready on the timeout edge still transfers.
//
// Build option: define ARB_FIXED_PRIO_EN for strict priority 3>2>1>0
// (the rotating pointer register is removed, the search always starts at 3).
module rr_onehot_arbiter
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int READY_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt,
  output logic              gnt_valid,
  input  logic              gnt_ready,
  output logic [NUM_CH-1:0] ovf,
  input  logic              ovf_clr,
  output logic              tmo
);

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] win;
  logic [NUM_CH-1:0] done_vec;
  logic [1:0]        search_ptr;
  logic              hs;
  logic              expire;

  // Transfer of the current offer, and withdrawal on the edge where the
  // wait counter would reach READY_TIMEOUT (ready has precedence)
  assign hs       = (state == ST_OFFER) && gnt_ready;
  assign expire   = (state == ST_OFFER) && !gnt_ready &&
                    (cnt == CNT_W'(READY_TIMEOUT - 1));
  assign done_vec = hs ? gnt : '0;

`ifdef ARB_FIXED_PRIO_EN
  assign search_ptr = ENC_A_IDX;
`else
  logic [1:0] ptr;
  logic [1:0] gnt_idx;

  assign gnt_idx    = onehot_to_idx(gnt);
  assign search_ptr = ptr;

  // Move the search start just below the last offered channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd3;
    end else if (hs || expire) begin
      ptr <= gnt_idx - 2'd1;
    end
  end
`endif

  rr_pick4 u_pick (
    .pending (pending),
    .ptr     (search_ptr),
    .win     (win)
  );

  // Pending bits: set by a request, cleared only by a transfer on that
  // channel; a same-cycle request re-arms the bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~done_vec) | req;
    end
  end

  // Sticky overflow: request on an already pending channel that is not
  // being transferred this cycle; a clear overrides a same-cycle set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= '0;
    end else if (ovf_clr) begin
      ovf <= '0;
    end else begin
      ovf <= ovf | (req & pending & ~done_vec);
    end
  end

  // Offer FSM: registers the winner, holds it, and ends on transfer or timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      tmo       <= 1'b0;
      cnt       <= '0;
    end else begin
      tmo <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|pending) begin
            state     <= ST_OFFER;
            gnt       <= win;
            gnt_valid <= 1'b1;
            cnt       <= '0;
          end
        end
        ST_OFFER: begin
          if (hs) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
          end else if (expire) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            tmo       <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Testbench for rr_onehot_arbiter (READY_TIMEOUT = 3). Each step drives
// inputs, waits for a rising edge, advances a channel-level reference
// model and the calling task compares outputs 1 ns after the edge.
module tb_rr_onehot_arbiter;

  localparam int T = 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       gnt_ready;
  logic [3:0] ovf;
  logic       ovf_clr;
  logic       tmo;

  int n_cmp;
  int n_bad;

  // Reference model: pending set, sticky overflow, offered channel number,
  // cycles the current offer has been waiting, and search start channel
  bit [3:0] m_pend;
  bit [3:0] m_ovf;
  bit       m_valid;
  bit       m_tmo;
  int       m_win;
  int       m_wait;
  int       m_ptr;

  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];

  rr_onehot_arbiter #(.READY_TIMEOUT(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .tmo       (tmo)
  );

  // Clock and run-time guard
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish in time (got timeout, need finish)");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] m_gnt();
    return m_valid ? 4'(1 << m_win) : 4'b0000;
  endfunction

  function automatic int next_start(input int w);
`ifdef ARB_FIXED_PRIO_EN
    return 3;
`else
    return (w + 3) % 4;
`endif
  endfunction

  task automatic model_reset();
    m_pend  = '0;
    m_ovf   = '0;
    m_valid = 1'b0;
    m_tmo   = 1'b0;
    m_win   = 0;
    m_wait  = 0;
    m_ptr   = 3;
  endtask

  // One clock edge of the arbiter's rules applied to pre-edge state
  task automatic model_edge(input logic [3:0] r, input logic rdy, input logic clr);
    bit [3:0] old_p;
    bit [3:0] new_p;
    bit       take;
    bit       served;
    old_p = m_pend;
    take  = m_valid && rdy;
    for (int i = 0; i < 4; i++) begin
      served   = take && (m_win == i);
      new_p[i] = (old_p[i] && !served) || r[i];
      if (r[i] && old_p[i] && !served) m_ovf[i] = 1'b1;
    end
    if (clr) m_ovf = '0;
    m_tmo = 1'b0;
    if (!m_valid) begin
      if (old_p != 0) begin
        for (int k = 0; k < 4; k++) begin
          int c;
          c = (m_ptr - k + 4) % 4;
          if (!m_valid && old_p[c]) begin
            m_win   = c;
            m_valid = 1'b1;
            m_wait  = 0;
          end
        end
      end
    end else if (take) begin
      m_valid = 1'b0;
      m_ptr   = next_start(m_win);
    end else begin
      m_wait++;
      if (m_wait == T) begin
        m_valid = 1'b0;
        m_tmo   = 1'b1;
        m_ptr   = next_start(m_win);
      end
    end
    m_pend = new_p;
  endtask

  // Driver: apply inputs, take one edge, update model, settle 1 ns
  task automatic step(input logic [3:0] r, input logic rdy, input logic clr);
    req       = r;
    gnt_ready = rdy;
    ovf_clr   = clr;
    @(posedge clk);
    model_edge(r, rdy, clr);
    #1;
  endtask

  task automatic apply_reset();
    req       = '0;
    gnt_ready = 1'b0;
    ovf_clr   = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b need 0000", gnt); end
    n_cmp++; if (gnt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b need 0", gnt_valid); end
    n_cmp++; if (ovf !== 4'b0000) begin n_bad++; $display("FAIL reset_ovf: got %b need 0000", ovf); end
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL reset_tmo: got %b need 0", tmo); end
    repeat (3) begin
      step(4'b0000, 1'b1, 1'b0);
      n_cmp++;
      if ({gnt, gnt_valid, ovf, tmo} !== {m_gnt(), m_valid, m_ovf, m_tmo}) begin
        n_bad++; $display("FAIL reset_idle: got %b/%b/%b/%b need %b/%b/%b/%b",
                          gnt, gnt_valid, ovf, tmo, m_gnt(), m_valid, m_ovf, m_tmo);
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] need_gnt [4] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000};
    logic       need_val [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    apply_reset();
    for (int s = 0; s < 4; s++) begin
      step((s == 0) ? 4'b0010 : 4'b0000, 1'b1, 1'b0);
      n_cmp++;
      if (gnt !== need_gnt[s] || gnt_valid !== need_val[s]) begin
        n_bad++; $display("FAIL single_step%0d: got gnt=%b v=%b need gnt=%b v=%b",
                          s, gnt, gnt_valid, need_gnt[s], need_val[s]);
      end
      n_cmp++;
      if ({gnt, gnt_valid, tmo} !== {m_gnt(), m_valid, m_tmo}) begin
        n_bad++; $display("FAIL single_model%0d: got %b/%b/%b need %b/%b/%b",
                          s, gnt, gnt_valid, tmo, m_gnt(), m_valid, m_tmo);
      end
    end
  endtask

  task automatic test_all_four();
    logic       prev_v;
    logic [3:0] r;
    apply_reset();
    exp_q.delete();
    got_q.delete();
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < 6; i++) exp_q.push_back(4'b1000);
`else
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
`endif
    prev_v = 1'b0;
    for (int s = 0; s < 13; s++) begin
`ifdef ARB_FIXED_PRIO_EN
      r = 4'b1111;
`else
      r = (s == 0) ? 4'b1111 : 4'b0000;
`endif
      step(r, 1'b1, 1'b0);
      n_cmp++;
      if ({gnt, gnt_valid, tmo} !== {m_gnt(), m_valid, m_tmo}) begin
        n_bad++; $display("FAIL all4_model%0d: got %b/%b/%b need %b/%b/%b",
                          s, gnt, gnt_valid, tmo, m_gnt(), m_valid, m_tmo);
      end
      if (gnt_valid === 1'b1) begin
        n_cmp++;
        if (prev_v !== 1'b0) begin
          n_bad++; $display("FAIL all4_gap%0d: got back-to-back offers need idle cycle", s);
        end
        got_q.push_back(gnt);
      end
      prev_v = gnt_valid;
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL all4_count: got %0d offers need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL all4_order%0d: got %b need %b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    // inputs per step: req, ready; required gnt, valid, tmo afterwards
    logic [3:0] s_req [10] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                              4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic       s_rdy [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] n_gnt [10] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                              4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    logic       n_val [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                              1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       n_tmo [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    apply_reset();
    for (int s = 0; s < 10; s++) begin
      step(s_req[s], s_rdy[s], 1'b0);
      n_cmp++;
      if (gnt !== n_gnt[s] || gnt_valid !== n_val[s] || tmo !== n_tmo[s]) begin
        n_bad++; $display("FAIL timeout_step%0d: got gnt=%b v=%b tmo=%b need gnt=%b v=%b tmo=%b",
                          s, gnt, gnt_valid, tmo, n_gnt[s], n_val[s], n_tmo[s]);
      end
      n_cmp++;
      if ({gnt, gnt_valid, tmo} !== {m_gnt(), m_valid, m_tmo}) begin
        n_bad++; $display("FAIL timeout_model%0d: got %b/%b/%b need %b/%b/%b",
                          s, gnt, gnt_valid, tmo, m_gnt(), m_valid, m_tmo);
      end
    end
  endtask

  task automatic test_ovf();
    logic [3:0] s_req [7] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    logic       s_rdy [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       s_clr [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] n_ovf [7] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic       n_val [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    apply_reset();
    for (int s = 0; s < 7; s++) begin
      step(s_req[s], s_rdy[s], s_clr[s]);
      n_cmp++;
      if (ovf !== n_ovf[s] || gnt_valid !== n_val[s] || tmo !== 1'b0) begin
        n_bad++; $display("FAIL ovf_step%0d: got ovf=%b v=%b tmo=%b need ovf=%b v=%b tmo=0",
                          s, ovf, gnt_valid, tmo, n_ovf[s], n_val[s]);
      end
      n_cmp++;
      if ({gnt, gnt_valid, ovf, tmo} !== {m_gnt(), m_valid, m_ovf, m_tmo}) begin
        n_bad++; $display("FAIL ovf_model%0d: got %b/%b/%b/%b need %b/%b/%b/%b",
                          s, gnt, gnt_valid, ovf, tmo, m_gnt(), m_valid, m_ovf, m_tmo);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    n_cmp++;
    if (gnt !== 4'b0100 || gnt_valid !== 1'b1) begin
      n_bad++; $display("FAIL arst_offer: got gnt=%b v=%b need gnt=0100 v=1", gnt, gnt_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
      n_bad++; $display("FAIL arst_drop: got gnt=%b v=%b need gnt=0000 v=0", gnt, gnt_valid);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      step(4'b0000, 1'b1, 1'b0);
      n_cmp++;
      if (gnt_valid !== 1'b0 || gnt !== 4'b0000) begin
        n_bad++; $display("FAIL arst_empty: got gnt=%b v=%b need gnt=0000 v=0", gnt, gnt_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       rdy;
    logic       clr;
    apply_reset();
    for (int s = 0; s < 600; s++) begin
      r   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      rdy = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 15) == 0);
      step(r, rdy, clr);
      n_cmp++;
      if ({gnt, gnt_valid, ovf, tmo} !== {m_gnt(), m_valid, m_ovf, m_tmo}) begin
        n_bad++; $display("FAIL random%0d: got %b/%b/%b/%b need %b/%b/%b/%b",
                          s, gnt, gnt_valid, ovf, tmo, m_gnt(), m_valid, m_ovf, m_tmo);
      end
      n_cmp++;
      if ($countones(gnt) > 1) begin
        n_bad++; $display("FAIL random_onehot%0d: got %b need at most one hot", s, gnt);
      end
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    req       = '0;
    gnt_ready = 1'b0;
    ovf_clr   = 1'b0;
    test_reset();
    test_single();
    test_all_four();
    test_timeout();
    test_ovf();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_onehot_arbiter.md
# rr_onehot_arbiter

- Four-channel request capture and round-robin arbiter feeding the 4-to-2 priority encoder stage.
- Latches single-cycle request pulses, picks one winner, and presents it as a one-hot grant with a valid/ready handshake.
- Guarantees the encoder sees at most one hot input per offer.
- A per-offer timeout prevents a stalled consumer from locking the arbiter.

## Interface
- READY_TIMEOUT, 15: max cycles an offer waits for gnt_ready before withdrawal; legal 1..255.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request pulses; req[3..0] map to encoder inputs a,b,c,d
- gnt  output  4  one-hot grant, same bit mapping as req; zero when not offering
- gnt_valid  output  1  offer present
- gnt_ready  input  1  consumer accepts offer
- ovf  output  4  sticky: request arrived while that channel already pending
- ovf_clr  input  1  clears all ovf bits
- tmo  output  1  one-cycle pulse: offer withdrawn on timeout

## Operation
- pending[3:0] register.
  - pending[i] sets on req[i].
  - It clears only when channel i's offer completes a handshake.
- ovf[i] sets when req[i]=1 and pending[i] is already 1, except in the handshake cycle for channel i.
  - ovf_clr wins over a same-cycle set.
- ptr[1:0] is the start channel for the search. Reset value is 3.
  - Search order: ptr, ptr-1, … with wrap 0→3.
  - The first pending channel wins.
- FSM states:
  - IDLE:
    - pending≠0 → OFFER; the winner is registered into gnt and gnt_valid=1.
    - Otherwise stay in IDLE.
  - OFFER:
    - gnt and gnt_valid are held stable and the timeout counter increments.
    - gnt_valid&gnt_ready → IDLE. The winner's pending bit clears and ptr = winner−1 (mod 4).
    - Counter reaches READY_TIMEOUT without ready → IDLE. tmo pulses, the pending bit is kept, and ptr = winner−1.
  - Encoding: IDLE=0, OFFER=1; 1-bit state register.
- Timeout counter is 8-bit, cleared on entry to OFFER.
- Requests arriving during OFFER only update pending; the offer never changes mid-handshake.

## Timing
- Reset values: gnt=0, gnt_valid=0, ovf=0, tmo=0, pending=0, ptr=3, state=IDLE, counter=0.
- All outputs are registered.
- Latency is 2 cycles from a req pulse at edge k:
  - pending is set after edge k.
  - gnt_valid is high after edge k+1.
- Handshake at edge h: gnt and gnt_valid are low after h. The earliest next offer is high after h+1, so there is one idle cycle minimum between offers.
- Same-cycle req[i] and handshake on i: pending[i] remains 1, the new request is kept, and ovf is not set.
- Timeout fires on the edge where the counter equals READY_TIMEOUT, i.e. READY_TIMEOUT cycles of gnt_valid without ready.
  - gnt_ready arriving on that same edge takes precedence: handshake completes and there is no tmo.
- rst_n low mid-offer: outputs go to reset values immediately, pending is lost, and the consumer must tolerate gnt_valid dropping asynchronously.
- Deassertion is synchronized by the system reset controller upstream.

## Configuration
- ARB_FIXED_PRIO_EN defined:
  - ptr is held at 3, so channel 3 always wins when pending (strict priority 3>2>1>0).
  - The ptr register is removed.
- Undefined: round-robin as described above.
- All other behaviour is identical in both builds.

## Structure
- Shared include holds:
  - channel count (4)
  - state encodings
  - counter width (8)
  - the channel→encoder-input mapping constants
- One sub-module, rr_pick4: combinational search returning the one-hot winner given pending and ptr. The fixed-priority build passes ptr=3.
- FSM, pending/ovf registers and timeout counter live in the top module.

## Test plan
- Reset with req=0000 → gnt=0000, gnt_valid=0, ovf=0000, tmo=0.
- Pulse req=0010 one cycle, gnt_ready=1 → gnt=0010 and gnt_valid=1 two cycles later for one cycle; pending is empty afterwards.
- Pulse req=1111 once, gnt_ready=1 → grants 1000, 0100, 0010, 0001 in order, each separated by one idle cycle. With ARB_FIXED_PRIO_EN and req held at 1111 every cycle, grants are always 1000.
- Pending channel 0, gnt_ready=0, READY_TIMEOUT=3:
  - gnt=0001 for 3 cycles, then tmo=1 for one cycle and gnt=0000.
  - The channel is re-offered after one idle cycle.
- Pulse req[1] twice while channel 1 is pending and not yet accepted → ovf=0010; ovf_clr → ovf=0000.
- Assert rst_n=0 mid-OFFER → gnt and gnt_valid go to 0 without a clock edge; after release, pending is empty.
